// File: rtl/spi_sample_sequencer.sv
// Periodic SPI acquisition sequencer.
// Every sample period it sweeps channels 0..NUM_CHANNELS-1, issuing one SPI
// frame per channel through the controller's start/idle handshake, and pushes
// each {channel, received frame} into a show-ahead FIFO drained by valid/ready.
// Dropped samples and ticks that land mid-sweep are counted (saturating).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a period tick while the controller reports idle
// ISSUE | spi_start_o high with cmd(ch); waiting for the controller to go busy
// BUSY  | frame in flight; capture rx when the controller returns to idle
module spi_sample_sequencer #(
    parameter int FRAME_WIDTH   = 32,
    parameter int NUM_CHANNELS  = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int FIFO_DEPTH    = 8,
    parameter int CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   enable_i,
    input  logic                   clear_i,
    output logic                   spi_start_o,
    input  logic                   spi_idle_i,
    output logic [FRAME_WIDTH-1:0] spi_tx_o,
    input  logic [FRAME_WIDTH-1:0] spi_rx_i,
    output logic [FRAME_WIDTH-1:0] sample_o,
    output logic [CH_W-1:0]        channel_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overflow_o,
    output logic [7:0]             drop_count_o,
    output logic [7:0]             missed_count_o
);

    localparam int PCNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CHANNELS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    logic [PCNT_W-1:0]      period_cnt;
    logic                   tick;
    logic [1:0]             state;
    logic [CH_W-1:0]        ch;
    logic [CH_W-1:0]        ch_next;
    logic                   capture;
    logic                   miss;

    logic [FRAME_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [CH_W-1:0]        mem_ch   [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_cnt;
    logic                   push;
    logic                   pop;
    logic                   drop;

    // Channel index goes out first, in the top byte of the frame.
    function automatic logic [FRAME_WIDTH-1:0] cmd_word(input logic [CH_W-1:0] c);
        logic [7:0] c8;
        c8 = 8'(c);
        return {c8, {(FRAME_WIDTH-8){1'b0}}};
    endfunction

    assign tick    = enable_i && (period_cnt == PCNT_LAST);
    assign ch_next = ch + 1'b1;
    assign capture = (state == ST_BUSY) && spi_idle_i;
    // A tick is lost unless it finds the FSM idle and the controller free.
    assign miss    = tick && !((state == ST_IDLE) && spi_idle_i);

    assign valid_o   = (fifo_cnt != '0);
    assign pop       = valid_o && ready_i;
    assign push      = capture && ((fifo_cnt != CNT_FULL) || pop);
    assign drop      = capture && !push;
    assign sample_o  = valid_o ? mem_data[rd_ptr] : '0;
    assign channel_o = valid_o ? mem_ch[rd_ptr] : '0;

    // Sample-period counter: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            period_cnt <= '0;
        end else if (!enable_i || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Sweep FSM with registered start strobe and command word.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= ST_IDLE;
            ch          <= '0;
            spi_start_o <= 1'b0;
            spi_tx_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick && spi_idle_i) begin
                        state       <= ST_ISSUE;
                        ch          <= '0;
                        spi_start_o <= 1'b1;
                        spi_tx_o    <= cmd_word('0);
                    end
                end
                ST_ISSUE: begin
                    if (!spi_idle_i) begin
                        state       <= ST_BUSY;
                        spi_start_o <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (spi_idle_i) begin
                        if (ch == CH_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            state       <= ST_ISSUE;
                            ch          <= ch_next;
                            spi_start_o <= 1'b1;
                            spi_tx_o    <= cmd_word(ch_next);
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    spi_start_o <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because valid_o gates the head.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr] <= spi_rx_i;
            mem_ch[wr_ptr]   <= ch;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sticky overflow and saturating drop/miss counters; clear wins.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            overflow_o     <= 1'b0;
            drop_count_o   <= '0;
            missed_count_o <= '0;
        end else if (clear_i) begin
            overflow_o     <= 1'b0;
            drop_count_o   <= '0;
            missed_count_o <= '0;
        end else begin
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_count_o != 8'hFF) begin
                    drop_count_o <= drop_count_o + 1'b1;
                end
            end
            if (miss && (missed_count_o != 8'hFF)) begin
                missed_count_o <= missed_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_sample_sequencer.sv
// Directed bench for spi_sample_sequencer with a behavioural SPI controller
// that echoes 0xA5A50000 | channel after a programmable frame length.
module tb_spi_sample_sequencer;

    localparam int FW  = 32;
    localparam int NCH = 4;
    localparam int SP  = 100;
    localparam int FD  = 8;
    localparam int CHW = 2;

    logic          clk_i = 1'b0;
    logic          reset_ni;
    logic          enable_i;
    logic          clear_i;
    logic          spi_start_o;
    logic          spi_idle_i;
    logic [FW-1:0] spi_tx_o;
    logic [FW-1:0] spi_rx_i;
    logic [FW-1:0] sample_o;
    logic [CHW-1:0] channel_o;
    logic          valid_o;
    logic          ready_i;
    logic          overflow_o;
    logic [7:0]    drop_count_o;
    logic [7:0]    missed_count_o;

    int compared   = 0;
    int mismatched = 0;

    spi_sample_sequencer #(
        .FRAME_WIDTH  (FW),
        .NUM_CHANNELS (NCH),
        .SAMPLE_PERIOD(SP),
        .FIFO_DEPTH   (FD),
        .CH_W         (CHW)
    ) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .enable_i      (enable_i),
        .clear_i       (clear_i),
        .spi_start_o   (spi_start_o),
        .spi_idle_i    (spi_idle_i),
        .spi_tx_o      (spi_tx_o),
        .spi_rx_i      (spi_rx_i),
        .sample_o      (sample_o),
        .channel_o     (channel_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .overflow_o    (overflow_o),
        .drop_count_o  (drop_count_o),
        .missed_count_o(missed_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Controller model: latches data while idle, goes busy one cycle after
    // sampling start, stays busy frame_len cycles, then returns the echo.
    int          frame_len = 10;
    logic        ctl_idle  = 1'b1;
    logic [31:0] ctl_rx    = '0;
    int          ctl_cnt   = 0;
    logic [7:0]  ctl_ch    = '0;

    assign spi_idle_i = ctl_idle;
    assign spi_rx_i   = ctl_rx;

    always @(posedge clk_i) begin
        if (ctl_idle) begin
            if (spi_start_o) begin
                ctl_idle <= 1'b0;
                ctl_cnt  <= frame_len;
                ctl_ch   <= spi_tx_o[31:24];
            end
        end else if (ctl_cnt <= 1) begin
            ctl_idle <= 1'b1;
            ctl_rx   <= 32'hA5A50000 | {24'h0, ctl_ch};
        end else begin
            ctl_cnt <= ctl_cnt - 1;
        end
    end

    // Observers: record popped entries and rising edges of spi_start_o.
    logic [33:0] pop_q[$];
    int          start_cnt     = 0;
    logic [31:0] last_start_tx = '0;
    logic        start_prev    = 1'b0;

    always @(negedge clk_i) begin
        if (valid_o && ready_i) pop_q.push_back({channel_o, sample_o});
        if (spi_start_o && !start_prev) begin
            start_cnt     = start_cnt + 1;
            last_start_tx = spi_tx_o;
        end
        start_prev = spi_start_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (start_cnt < target && k < budget) begin step(); k++; end
        if (start_cnt < target) begin
            compared++; mismatched++;
            $display("FAIL %s: timeout, starts seen %0d required %0d", name, start_cnt, target);
        end
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (pop_q.size() < n && k < budget) begin step(); k++; end
        if (pop_q.size() < n) begin
            compared++; mismatched++;
            $display("FAIL %s: timeout, pops seen %0d required %0d", name, pop_q.size(), n);
        end
    endtask

    task automatic wait_start_tx(input logic [31:0] tx, input int budget, input string name);
        int k;
        int c;
        bit hit;
        k = 0; c = start_cnt; hit = 0;
        while (!hit && k < budget) begin
            step(); k++;
            if (start_cnt != c) begin
                if (last_start_tx == tx) hit = 1;
                c = start_cnt;
            end
        end
        if (!hit) begin
            compared++; mismatched++;
            $display("FAIL %s: timeout waiting for start with tx %h", name, tx);
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; enable_i = 1'b0; clear_i = 1'b0; ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        compared++; if (spi_start_o !== 1'b0) begin mismatched++; $display("FAIL rst_start: got %0b need 0", spi_start_o); end
        compared++; if (spi_tx_o !== 32'h0) begin mismatched++; $display("FAIL rst_tx: got %h need 0", spi_tx_o); end
        compared++; if (valid_o !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %0b need 0", valid_o); end
        compared++; if (sample_o !== 32'h0) begin mismatched++; $display("FAIL rst_sample: got %h need 0", sample_o); end
        compared++; if (channel_o !== 2'd0) begin mismatched++; $display("FAIL rst_channel: got %0d need 0", channel_o); end
        compared++; if (overflow_o !== 1'b0) begin mismatched++; $display("FAIL rst_overflow: got %0b need 0", overflow_o); end
        compared++; if (drop_count_o !== 8'd0) begin mismatched++; $display("FAIL rst_drop: got %0d need 0", drop_count_o); end
        compared++; if (missed_count_o !== 8'd0) begin mismatched++; $display("FAIL rst_missed: got %0d need 0", missed_count_o); end
        step();
        reset_ni = 1'b1;
        repeat (3) step();
        @(negedge clk_i);
        compared++; if (spi_start_o !== 1'b0) begin mismatched++; $display("FAIL rst_rel_start: got %0b need 0", spi_start_o); end
        compared++; if (dut.period_cnt !== 7'd0) begin mismatched++; $display("FAIL rst_rel_pcnt: got %0d need 0", dut.period_cnt); end
    endtask

    task automatic test_basic_sweep();
        int sc0;
        logic [33:0] exp;
        step();
        ready_i = 1'b1; enable_i = 1'b1; frame_len = 10;
        pop_q.delete();
        sc0 = start_cnt;
        wait_pops(4, 250, "basic_pops1");
        for (int k = 0; k < 4; k++) begin
            exp = {CHW'(k), 32'hA5A50000 | 32'(k)};
            compared++;
            if (pop_q[k] !== exp) begin
                mismatched++;
                $display("FAIL basic1_%0d: got ch=%0d data=%h need ch=%0d data=%h", k, pop_q[k][33:32], pop_q[k][31:0], exp[33:32], exp[31:0]);
            end
        end
        compared++; if (start_cnt - sc0 != 4) begin mismatched++; $display("FAIL basic_starts: got %0d need 4", start_cnt - sc0); end
        compared++; if (last_start_tx !== 32'h03000000) begin mismatched++; $display("FAIL basic_cmd3: got %h need 03000000", last_start_tx); end
        wait_pops(8, 150, "basic_pops2");
        for (int k = 0; k < 4; k++) begin
            exp = {CHW'(k), 32'hA5A50000 | 32'(k)};
            compared++;
            if (pop_q[k+4] !== exp) begin
                mismatched++;
                $display("FAIL basic2_%0d: got ch=%0d data=%h need ch=%0d data=%h", k, pop_q[k+4][33:32], pop_q[k+4][31:0], exp[33:32], exp[31:0]);
            end
        end
        compared++; if (missed_count_o !== 8'd0) begin mismatched++; $display("FAIL basic_missed: got %0d need 0", missed_count_o); end
        compared++; if (overflow_o !== 1'b0) begin mismatched++; $display("FAIL basic_overflow: got %0b need 0", overflow_o); end
    endtask

    task automatic test_backpressure();
        int sc0;
        logic [33:0] exp;
        ready_i = 1'b0;
        clear_i = 1'b1; step(); clear_i = 1'b0;
        sc0 = start_cnt;
        wait_starts(sc0 + 12, 400, "bp_starts");
        repeat (30) step();
        @(negedge clk_i);
        compared++; if (dut.fifo_cnt !== 4'd8) begin mismatched++; $display("FAIL bp_count: got %0d need 8", dut.fifo_cnt); end
        compared++; if (valid_o !== 1'b1) begin mismatched++; $display("FAIL bp_valid: got %0b need 1", valid_o); end
        compared++; if (overflow_o !== 1'b1) begin mismatched++; $display("FAIL bp_overflow: got %0b need 1", overflow_o); end
        compared++; if (drop_count_o !== 8'd4) begin mismatched++; $display("FAIL bp_drop: got %0d need 4", drop_count_o); end
        compared++; if (channel_o !== 2'd0) begin mismatched++; $display("FAIL bp_head_ch: got %0d need 0", channel_o); end
        compared++; if (sample_o !== 32'hA5A50000) begin mismatched++; $display("FAIL bp_head_data: got %h need a5a50000", sample_o); end
        compared++; if (missed_count_o !== 8'd0) begin mismatched++; $display("FAIL bp_missed: got %0d need 0", missed_count_o); end
        step();
        pop_q.delete();
        ready_i = 1'b1;
        wait_pops(8, 20, "bp_drain");
        for (int k = 0; k < 8; k++) begin
            exp = {CHW'(k % 4), 32'hA5A50000 | 32'(k % 4)};
            compared++;
            if (pop_q[k] !== exp) begin
                mismatched++;
                $display("FAIL bp_drain_%0d: got ch=%0d data=%h need ch=%0d data=%h", k, pop_q[k][33:32], pop_q[k][31:0], exp[33:32], exp[31:0]);
            end
        end
        @(negedge clk_i);
        compared++; if (valid_o !== 1'b0) begin mismatched++; $display("FAIL bp_empty: got valid %0b need 0", valid_o); end
    endtask

    task automatic test_full_same_cycle_pop();
        int sc0;
        int k;
        logic prev;
        bit hit;
        logic [33:0] exp;
        int exp_ch[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        ready_i = 1'b0;
        clear_i = 1'b1; step(); clear_i = 1'b0;
        sc0 = start_cnt;
        wait_starts(sc0 + 9, 400, "full_starts");
        prev = spi_idle_i; hit = 0; k = 0;
        while (!hit && k < 50) begin
            step(); k++;
            if (spi_idle_i && !prev) hit = 1;
            prev = spi_idle_i;
        end
        if (!hit) begin
            compared++; mismatched++;
            $display("FAIL full_idle_rise: timeout waiting for end of frame");
        end
        pop_q.delete();
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        @(negedge clk_i);
        compared++; if (dut.fifo_cnt !== 4'd8) begin mismatched++; $display("FAIL full_count: got %0d need 8", dut.fifo_cnt); end
        compared++; if (drop_count_o !== 8'd0) begin mismatched++; $display("FAIL full_drop: got %0d need 0", drop_count_o); end
        compared++; if (overflow_o !== 1'b0) begin mismatched++; $display("FAIL full_overflow: got %0b need 0", overflow_o); end
        compared++; if (pop_q.size() != 1) begin mismatched++; $display("FAIL full_popcount: got %0d need 1", pop_q.size()); end
        compared++; if (pop_q[0] !== {2'd0, 32'hA5A50000}) begin mismatched++; $display("FAIL full_popped: got %h need 0a5a50000", pop_q[0]); end
        wait_starts(sc0 + 12, 100, "full_starts_end");
        repeat (20) step();
        @(negedge clk_i);
        compared++; if (drop_count_o !== 8'd3) begin mismatched++; $display("FAIL full_drop_end: got %0d need 3", drop_count_o); end
        compared++; if (overflow_o !== 1'b1) begin mismatched++; $display("FAIL full_overflow_end: got %0b need 1", overflow_o); end
        step();
        pop_q.delete();
        ready_i = 1'b1;
        wait_pops(8, 20, "full_drain");
        for (int i = 0; i < 8; i++) begin
            exp = {CHW'(exp_ch[i]), 32'hA5A50000 | 32'(exp_ch[i])};
            compared++;
            if (pop_q[i] !== exp) begin
                mismatched++;
                $display("FAIL full_drain_%0d: got ch=%0d data=%h need ch=%0d data=%h", i, pop_q[i][33:32], pop_q[i][31:0], exp[33:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_overrun();
        int sc0;
        int k;
        step();
        frame_len = 70;
        sc0 = start_cnt;
        compared++; if (missed_count_o !== 8'd0) begin mismatched++; $display("FAIL ovr_missed0: got %0d need 0", missed_count_o); end
        wait_starts(sc0 + 5, 500, "ovr_sweep1");
        @(negedge clk_i);
        compared++; if (missed_count_o !== 8'd2) begin mismatched++; $display("FAIL ovr_missed1: got %0d need 2", missed_count_o); end
        compared++; if (drop_count_o !== 8'd3) begin mismatched++; $display("FAIL ovr_drop_kept: got %0d need 3", drop_count_o); end
        wait_starts(sc0 + 9, 400, "ovr_sweep2");
        @(negedge clk_i);
        compared++; if (missed_count_o !== 8'd4) begin mismatched++; $display("FAIL ovr_missed2: got %0d need 4", missed_count_o); end
        // Line clear_i up with a mid-sweep tick so the increment collides with it.
        k = 0;
        while (dut.period_cnt != 7'(SP - 1) && k < 200) begin step(); k++; end
        clear_i = 1'b1; step(); clear_i = 1'b0;
        @(negedge clk_i);
        compared++; if (missed_count_o !== 8'd0) begin mismatched++; $display("FAIL clr_missed: got %0d need 0", missed_count_o); end
        compared++; if (drop_count_o !== 8'd0) begin mismatched++; $display("FAIL clr_drop: got %0d need 0", drop_count_o); end
        compared++; if (overflow_o !== 1'b0) begin mismatched++; $display("FAIL clr_overflow: got %0b need 0", overflow_o); end
        step();
        k = 0;
        while (dut.period_cnt != 7'(SP - 1) && k < 200) begin step(); k++; end
        step();
        @(negedge clk_i);
        compared++; if (missed_count_o !== 8'd1) begin mismatched++; $display("FAIL ovr_after_clr: got %0d need 1", missed_count_o); end
    endtask

    task automatic test_reset_mid_frame();
        int sc1;
        wait_start_tx(32'h01000000, 400, "rmf_ch1");
        frame_len = 200;
        wait_start_tx(32'h02000000, 200, "rmf_ch2");
        repeat (10) step();
        #2 reset_ni = 1'b0;
        #1;
        compared++; if (spi_start_o !== 1'b0) begin mismatched++; $display("FAIL rmf_start: got %0b need 0", spi_start_o); end
        compared++; if (spi_tx_o !== 32'h0) begin mismatched++; $display("FAIL rmf_tx: got %h need 0", spi_tx_o); end
        compared++; if (valid_o !== 1'b0) begin mismatched++; $display("FAIL rmf_valid: got %0b need 0", valid_o); end
        compared++; if (sample_o !== 32'h0) begin mismatched++; $display("FAIL rmf_sample: got %h need 0", sample_o); end
        compared++; if (channel_o !== 2'd0) begin mismatched++; $display("FAIL rmf_channel: got %0d need 0", channel_o); end
        compared++; if (overflow_o !== 1'b0) begin mismatched++; $display("FAIL rmf_overflow: got %0b need 0", overflow_o); end
        compared++; if (drop_count_o !== 8'd0) begin mismatched++; $display("FAIL rmf_drop: got %0d need 0", drop_count_o); end
        compared++; if (missed_count_o !== 8'd0) begin mismatched++; $display("FAIL rmf_missed: got %0d need 0", missed_count_o); end
        step(); step();
        reset_ni = 1'b1;
        sc1 = start_cnt;
        repeat (150) step();
        @(negedge clk_i);
        compared++; if (start_cnt != sc1) begin mismatched++; $display("FAIL rmf_no_start: got %0d starts need 0", start_cnt - sc1); end
        compared++; if (missed_count_o !== 8'd1) begin mismatched++; $display("FAIL rmf_busy_tick: got missed %0d need 1", missed_count_o); end
        compared++; if (valid_o !== 1'b0) begin mismatched++; $display("FAIL rmf_no_capture: got valid %0b need 0", valid_o); end
        step();
        frame_len = 10;
        wait_start_tx(32'h00000000, 100, "rmf_restart");
        compared++; if (start_cnt - sc1 != 1) begin mismatched++; $display("FAIL rmf_restart_cnt: got %0d need 1", start_cnt - sc1); end
    endtask

    task automatic test_enable_toggle();
        int sc;
        int n;
        wait_start_tx(32'h01000000, 100, "en_ch1");
        enable_i = 1'b0;
        sc = start_cnt;
        repeat (60) step();
        @(negedge clk_i);
        compared++; if (start_cnt - sc != 2) begin mismatched++; $display("FAIL en_finish_cnt: got %0d need 2", start_cnt - sc); end
        compared++; if (last_start_tx !== 32'h03000000) begin mismatched++; $display("FAIL en_finish_ch3: got %h need 03000000", last_start_tx); end
        compared++; if (dut.period_cnt !== 7'd0) begin mismatched++; $display("FAIL en_pcnt_held: got %0d need 0", dut.period_cnt); end
        sc = start_cnt;
        repeat (250) step();
        @(negedge clk_i);
        compared++; if (start_cnt != sc) begin mismatched++; $display("FAIL en_no_tick: got %0d starts need 0", start_cnt - sc); end
        compared++; if (dut.period_cnt !== 7'd0) begin mismatched++; $display("FAIL en_pcnt_held2: got %0d need 0", dut.period_cnt); end
        step();
        enable_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!spi_start_o && n < 300);
        compared++; if (n != SP + 1) begin mismatched++; $display("FAIL en_tick_latency: got %0d cycles need %0d", n, SP + 1); end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_backpressure();
        test_full_same_cycle_pop();
        test_overrun();
        test_reset_mid_frame();
        test_enable_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
